// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-side arbiter.
// The md result struct and the source-select enum are used by the top and its FIFO.
package regfile_wb_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } md_result_t;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_PIPE   = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_md_fifo.sv
// Small synchronous FIFO for mul/div results waiting for the write port.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module wb_md_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  md_result_t din,
  output md_result_t dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  md_result_t     mem_r [DEPTH];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                 (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign dout  = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Pointer update; pushes when full and pops when empty are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges WB-stage and mul/div results onto the single register-file write port
// and tracks which registers still await a mul/div result.
module regfile_wb_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int MD_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wen,
  input  logic [ADDR_W-1:0]        pipe_waddr,
  input  logic [WIDTH-1:0]         pipe_wdata,
  input  logic                     md_issue_valid,
  input  logic [ADDR_W-1:0]        md_issue_addr,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [ADDR_W-1:0]        md_addr,
  input  logic [WIDTH-1:0]         md_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [WIDTH-1:0]         rf_wdata,
  output logic [(1<<ADDR_W)-1:0]   busy_mask,
  output logic                     waw_err
);

  localparam int NUM_REGS = 1 << ADDR_W;

  import regfile_wb_pkg::*;

  logic                pipe_live_s;
  logic                md_live_s;
  logic                issue_live_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                fifo_push_s;
  logic                fifo_pop_s;
  md_result_t          fifo_din_s;
  md_result_t          fifo_dout_s;
  wb_src_e             src_s;

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_vec_s;
  logic [NUM_REGS-1:0] clr_vec_s;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic                waw_set_s;
  logic                waw_r;

  logic                rf_we_r;
  logic [ADDR_W-1:0]   rf_waddr_r;
  logic [WIDTH-1:0]    rf_wdata_r;
  logic                rf_we_nxt_s;
  logic [ADDR_W-1:0]   rf_waddr_nxt_s;
  logic [WIDTH-1:0]    rf_wdata_nxt_s;

  // A full FIFO refuses new results even while it is being popped.
  assign md_ready     = rst_n && !fifo_full_s;
  assign pipe_live_s  = pipe_wen && (pipe_waddr != {ADDR_W{1'b0}});
  assign md_live_s    = md_valid && md_ready && (md_addr != {ADDR_W{1'b0}});
  assign issue_live_s = md_issue_valid && (md_issue_addr != {ADDR_W{1'b0}});

  // Write-port source priority: pipe, then queued md results, then bypass.
  always_comb begin
    src_s = SRC_NONE;
    if (pipe_live_s) begin
      src_s = SRC_PIPE;
    end else if (!fifo_empty_s) begin
      src_s = SRC_FIFO;
    end else if (md_live_s) begin
      src_s = SRC_BYPASS;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // FIFO control; r0-addressed results are handshaken but never stored.
  always_comb begin
    fifo_din_s.addr = md_addr;
    fifo_din_s.data = md_data;
    fifo_push_s     = md_live_s && (src_s != SRC_BYPASS);
    fifo_pop_s      = (src_s == SRC_FIFO);
  end

  wb_md_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next write-port contents; address and data hold when idle.
  always_comb begin
    rf_we_nxt_s    = 1'b0;
    rf_waddr_nxt_s = rf_waddr_r;
    rf_wdata_nxt_s = rf_wdata_r;
    case (src_s)
      SRC_PIPE: begin
        rf_we_nxt_s    = 1'b1;
        rf_waddr_nxt_s = pipe_waddr;
        rf_wdata_nxt_s = pipe_wdata;
      end
      SRC_FIFO: begin
        rf_we_nxt_s    = 1'b1;
        rf_waddr_nxt_s = fifo_dout_s.addr;
        rf_wdata_nxt_s = fifo_dout_s.data;
      end
      SRC_BYPASS: begin
        rf_we_nxt_s    = 1'b1;
        rf_waddr_nxt_s = md_addr;
        rf_wdata_nxt_s = md_data;
      end
      default: begin
        rf_we_nxt_s    = 1'b0;
      end
    endcase
  end

  // Scoreboard next state: a same-cycle set overrides the clear.
  always_comb begin
    set_vec_s = {NUM_REGS{1'b0}};
    clr_vec_s = {NUM_REGS{1'b0}};
    if (issue_live_s) begin
      set_vec_s[md_issue_addr] = 1'b1;
    end else begin
      set_vec_s = {NUM_REGS{1'b0}};
    end
    case (src_s)
      SRC_FIFO:   clr_vec_s[fifo_dout_s.addr] = 1'b1;
      SRC_BYPASS: clr_vec_s[md_addr] = 1'b1;
      default:    clr_vec_s = {NUM_REGS{1'b0}};
    endcase
    busy_nxt_s    = (busy_r & ~clr_vec_s) | set_vec_s;
    busy_nxt_s[0] = 1'b0;
    waw_set_s     = (pipe_live_s && busy_r[pipe_waddr]) ||
                    (issue_live_s && busy_r[md_issue_addr] && !clr_vec_s[md_issue_addr]);
  end

  // Registered write port, scoreboard and sticky WAW flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {WIDTH{1'b0}};
      busy_r     <= {NUM_REGS{1'b0}};
      waw_r      <= 1'b0;
    end else begin
      rf_we_r    <= rf_we_nxt_s;
      rf_waddr_r <= rf_waddr_nxt_s;
      rf_wdata_r <= rf_wdata_nxt_s;
      busy_r     <= busy_nxt_s;
      waw_r      <= waw_r | waw_set_s;
    end
  end

  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign busy_mask = busy_r;
  assign waw_err   = waw_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a pipe-only vector table plus
// hand-written md sequences, with all rf_* writes checked against an expected queue.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        md_issue_valid;
  logic [4:0]  md_issue_addr;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        waw_err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_we;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_wen       (pipe_wen),
    .pipe_waddr     (pipe_waddr),
    .pipe_wdata     (pipe_wdata),
    .md_issue_valid (md_issue_valid),
    .md_issue_addr  (md_issue_addr),
    .md_valid       (md_valid),
    .md_ready       (md_ready),
    .md_addr        (md_addr),
    .md_data        (md_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy_mask      (busy_mask),
    .waw_err        (waw_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wen       = 1'b0;
    pipe_waddr     = 5'd0;
    pipe_wdata     = 32'd0;
    md_issue_valid = 1'b0;
    md_issue_addr  = 5'd0;
    md_valid       = 1'b0;
    md_addr        = 5'd0;
    md_data        = 32'd0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_wen   = 1'b1;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic drive_md(input logic [4:0] a, input logic [31:0] d);
    md_valid = 1'b1;
    md_addr  = a;
    md_data  = d;
  endtask

  task automatic issue(input logic [4:0] a);
    md_issue_valid = 1'b1;
    md_issue_addr  = a;
  endtask

  // Every registered write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && rf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1};
    tbl[1] = '{1'b1, 5'd0,  32'h5555_5555, 1'b0};
    tbl[2] = '{1'b0, 5'd3,  32'h0000_0009, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1};
    tbl[5] = '{1'b1, 5'd2,  32'hCAFE_0002, 1'b1};

    // Reset with toggling inputs
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      pipe_wen       = 1'($urandom);
      pipe_waddr     = 5'($urandom);
      pipe_wdata     = $urandom;
      md_issue_valid = 1'($urandom);
      md_issue_addr  = 5'($urandom);
      md_valid       = 1'($urandom);
      md_addr        = 5'($urandom);
      md_data        = $urandom;
      #1;
      check("rst_md_ready_low", {31'd0, md_ready}, 32'd0);
      step();
    end
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_waw", {31'd0, waw_err}, 32'd0);
    idle();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    check("post_rst_md_ready", {31'd0, md_ready}, 32'd1);

    // Pipe-only vector table
    for (int i = 0; i < 6; i++) begin
      pipe_wen   = tbl[i].wen;
      pipe_waddr = tbl[i].addr;
      pipe_wdata = tbl[i].data;
      if (tbl[i].exp_we) expect_wr(tbl[i].addr, tbl[i].data);
      step();
      check("tbl_we", {31'd0, rf_we}, {31'd0, tbl[i].exp_we});
    end
    idle();
    step();
    check("idle_we", {31'd0, rf_we}, 32'd0);

    // Bypass path with scoreboard set/clear
    issue(5'd8);
    step();
    idle();
    check("bypass_busy_set", {31'd0, busy_mask[8]}, 32'd1);
    step();
    step();
    drive_md(5'd8, 32'h0000_DEAD);
    check("bypass_ready", {31'd0, md_ready}, 32'd1);
    expect_wr(5'd8, 32'h0000_DEAD);
    step();
    idle();
    check("bypass_we", {31'd0, rf_we}, 32'd1);
    check("bypass_busy_clr", {31'd0, busy_mask[8]}, 32'd0);

    // md result to r0 and issue to r0 are both discarded
    drive_md(5'd0, 32'h0000_0001);
    issue(5'd0);
    check("r0_md_ready", {31'd0, md_ready}, 32'd1);
    step();
    idle();
    check("r0_md_no_write", {31'd0, rf_we}, 32'd0);
    check("r0_busy", busy_mask, 32'd0);

    // Set/clear collision: set wins and is not a WAW
    issue(5'd6);
    step();
    idle();
    drive_md(5'd6, 32'h0000_0066);
    issue(5'd6);
    expect_wr(5'd6, 32'h0000_0066);
    step();
    idle();
    check("collide_busy", {31'd0, busy_mask[6]}, 32'd1);
    check("collide_no_waw", {31'd0, waw_err}, 32'd0);
    drive_md(5'd6, 32'h0000_0067);
    expect_wr(5'd6, 32'h0000_0067);
    step();
    idle();
    check("collide_busy_clr", {31'd0, busy_mask[6]}, 32'd0);

    // Contention and FIFO full: expected order r1..r4, r9, r10, r11 back-to-back
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd2, 32'h102);
    expect_wr(5'd3, 32'h103);
    expect_wr(5'd4, 32'h104);
    expect_wr(5'd9, 32'hA);
    expect_wr(5'd10, 32'hB);
    expect_wr(5'd11, 32'hC);
    drive_pipe(5'd1, 32'h101);
    drive_md(5'd9, 32'hA);
    check("cont_ready_c0", {31'd0, md_ready}, 32'd1);
    step();
    check("cont_we_c1", {31'd0, rf_we}, 32'd1);
    drive_pipe(5'd2, 32'h102);
    drive_md(5'd10, 32'hB);
    check("cont_ready_c1", {31'd0, md_ready}, 32'd1);
    step();
    check("cont_we_c2", {31'd0, rf_we}, 32'd1);
    drive_pipe(5'd3, 32'h103);
    drive_md(5'd11, 32'hC);
    check("third_md_ready", {31'd0, md_ready}, 32'd0);
    step();
    check("cont_we_c3", {31'd0, rf_we}, 32'd1);
    drive_pipe(5'd4, 32'h104);
    check("cont_ready_c3", {31'd0, md_ready}, 32'd0);
    step();
    check("cont_we_c4", {31'd0, rf_we}, 32'd1);
    pipe_wen = 1'b0;
    check("full_on_pop_ready", {31'd0, md_ready}, 32'd0);
    step();
    check("cont_we_c5", {31'd0, rf_we}, 32'd1);
    check("cont_ready_c5", {31'd0, md_ready}, 32'd1);
    step();
    idle();
    for (int c = 6; c < 8; c++) begin
      check("cont_we_tail", {31'd0, rf_we}, 32'd1);
      step();
    end
    check("cont_we_end", {31'd0, rf_we}, 32'd0);

    // WAW: pipe writes a register with a pending md result
    issue(5'd7);
    step();
    idle();
    check("waw_busy", {31'd0, busy_mask[7]}, 32'd1);
    check("waw_pre", {31'd0, waw_err}, 32'd0);
    drive_pipe(5'd7, 32'h77);
    expect_wr(5'd7, 32'h77);
    step();
    idle();
    check("waw_set", {31'd0, waw_err}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    check("waw_sticky", {31'd0, waw_err}, 32'd1);
    drive_md(5'd7, 32'h7777);
    expect_wr(5'd7, 32'h7777);
    step();
    idle();
    check("waw_busy_clr", {31'd0, busy_mask[7]}, 32'd0);
    check("waw_still", {31'd0, waw_err}, 32'd1);

    // Mid-operation reset flushes the FIFO and clears the flag
    drive_pipe(5'd1, 32'h201);
    drive_md(5'd12, 32'h1200);
    expect_wr(5'd1, 32'h201);
    step();
    drive_pipe(5'd2, 32'h202);
    drive_md(5'd13, 32'h1300);
    expect_wr(5'd2, 32'h202);
    step();
    idle();
    rst_n = 1'b0;
    step();
    check("mid_rst_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_waw", {31'd0, waw_err}, 32'd0);
    check("mid_rst_ready", {31'd0, md_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("flushed_no_write", {31'd0, rf_we}, 32'd0);
    check("flushed_ready", {31'd0, md_ready}, 32'd1);

    // WAW via a second issue to a still-pending register
    issue(5'd3);
    step();
    check("reissue_pre", {31'd0, waw_err}, 32'd0);
    step();
    idle();
    check("reissue_waw", {31'd0, waw_err}, 32'd1);
    drive_md(5'd3, 32'h33);
    expect_wr(5'd3, 32'h33);
    step();
    idle();
    check("reissue_busy_clr", busy_mask, 32'd0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
